// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and FSM state encoding
package spi_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_engine_if.sv
// rtl/spi_slave_engine_if.sv - SPI pins plus host TX/RX/status signals
interface spi_slave_engine_if;

  logic                            sclk;
  logic                            ss_n;
  logic                            mosi;
  logic                            miso;
  logic                            miso_oe;
  logic [spi_pkg::DATA_WIDTH-1:0]  tx_data;
  logic                            tx_write;
  logic                            tx_full;
  logic [spi_pkg::DATA_WIDTH-1:0]  rx_data;
  logic                            rx_read;
  logic                            rx_full;
  logic                            overrun;
  logic                            underrun;
  logic                            busy;
  logic                            err_clr;

  modport slave (
    input  sclk, ss_n, mosi, tx_data, tx_write, rx_read, err_clr,
    output miso, miso_oe, tx_full, rx_data, rx_full, overrun, underrun, busy
  );

  modport master (
    output sclk, ss_n, mosi, tx_data, tx_write, rx_read, err_clr,
    input  miso, miso_oe, tx_full, rx_data, rx_full, overrun, underrun, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-flop synchronizer with rise/fall detection
module spi_sync_edge #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta <= IDLE_LEVEL;
      sync <= IDLE_LEVEL;
      prev <= IDLE_LEVEL;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_slave_engine.sv
// rtl/spi_slave_engine.sv - SPI mode 0 slave with one-byte TX/RX buffers
module spi_slave_engine
  import spi_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  spi_slave_engine_if.slave   bus
);

  logic sclk_level_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_level;
  logic ss_rise_unused;
  logic ss_fall;
  logic mosi_meta;
  logic mosi_sync;

  spi_sync_edge #(.IDLE_LEVEL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .clr   (clr),
    .pin   (bus.sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.IDLE_LEVEL(1'b1)) u_ss_sync (
    .clk   (clk),
    .clr   (clr),
    .pin   (bus.ss_n),
    .level (ss_level),
    .rise  (ss_rise_unused),
    .fall  (ss_fall)
  );

  spi_state_e              state;
  spi_state_e              next_state;
  logic [CNT_WIDTH-1:0]    bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    sample;
  logic                    byte_done;
  logic                    rx_pend;
  logic [DATA_WIDTH-1:0]   tx_buf;
  logic                    tx_full;
  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    rx_full;
  logic                    overrun;
  logic                    underrun;
  logic [1:0]              warm_cnt;
  logic                    sync_ready;
  logic                    do_load;
  logic                    do_sample;
  logic                    do_shift;
  logic                    ovr_set;
  logic                    unr_set;
  logic [DATA_WIDTH-1:0]   rx_byte;

  // A held-low SS_N at reset release looks like a falling edge while the
  // synchronizer flushes its idle-level reset values; ignore it until settled.
  assign sync_ready = (warm_cnt == 2'd3);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      warm_cnt  <= 2'd0;
    end else begin
      mosi_meta <= bus.mosi;
      mosi_sync <= mosi_meta;
      if (!sync_ready) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    do_load    = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    if (ss_level) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ss_fall && sync_ready) begin
            next_state = ST_LOAD;
          end
        end
        ST_LOAD: begin
          do_load    = 1'b1;
          next_state = ST_SHIFT;
        end
        ST_SHIFT: begin
          do_sample = sclk_rise;
          if (sclk_fall) begin
            if (byte_done) begin
              next_state = ST_LOAD;
            end else begin
              do_shift = 1'b1;
            end
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign rx_byte = {shift_reg[DATA_WIDTH-2:0], sample};
  assign ovr_set = rx_pend & rx_full & ~bus.rx_read;
  assign unr_set = do_load & ~tx_full;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      sample    <= 1'b0;
      byte_done <= 1'b0;
      rx_pend   <= 1'b0;
    end else begin
      rx_pend <= do_sample && (bit_cnt == CNT_LAST);
      if (ss_level) begin
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else if (do_load) begin
        shift_reg <= tx_full ? tx_buf : '0;
        byte_done <= 1'b0;
      end else begin
        if (do_sample) begin
          sample  <= mosi_sync;
          bit_cnt <= bit_cnt + CNT_WIDTH'(1);
          if (bit_cnt == CNT_LAST) begin
            byte_done <= 1'b1;
          end
        end
        if (do_shift) begin
          shift_reg <= {shift_reg[DATA_WIDTH-2:0], sample};
        end
      end
    end
  end

  // A write coinciding with LOAD keeps the new byte pending; LOAD already used the old one.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (bus.tx_write) begin
      tx_buf  <= bus.tx_data;
      tx_full <= 1'b1;
    end else if (do_load) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rx_data  <= '0;
      rx_full  <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (rx_pend && !ovr_set) begin
        rx_data <= rx_byte;
        rx_full <= 1'b1;
      end else if (bus.rx_read) begin
        rx_full <= 1'b0;
      end
      overrun  <= ovr_set | (overrun & ~bus.err_clr);
      underrun <= unr_set | (underrun & ~bus.err_clr);
    end
  end

  assign bus.miso     = shift_reg[DATA_WIDTH-1];
  assign bus.miso_oe  = ~ss_level;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.tx_full  = tx_full;
  assign bus.rx_data  = rx_data;
  assign bus.rx_full  = rx_full;
  assign bus.overrun  = overrun;
  assign bus.underrun = underrun;

endmodule

// File: tb/tb_spi_slave_engine.sv
// tb/tb_spi_slave_engine.sv - directed bench for spi_slave_engine
module tb_spi_slave_engine;

  logic clk;
  logic clr;
  int   total;
  int   bad;
  logic [7:0] got;

  spi_slave_engine_if bus();

  spi_slave_engine dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SCLK half period of 8 CLK cycles gives SCLK = CLK/16
  task automatic half();
    cyc(8);
  endtask

  task automatic tx_wr(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_write = 1'b1;
    cyc(1);
    bus.tx_write = 1'b0;
  endtask

  task automatic rx_rd();
    bus.rx_read = 1'b1;
    cyc(1);
    bus.rx_read = 1'b0;
  endtask

  task automatic err_clear();
    bus.err_clr = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.mosi = mo[i];
      half();
      mi[i] = bus.miso;
      bus.sclk = 1'b1;
      half();
      bus.sclk = 1'b0;
    end
  endtask

  task automatic select();
    bus.ss_n = 1'b0;
    half();
  endtask

  task automatic deselect();
    half();
    bus.ss_n = 1'b1;
    cyc(4);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    clr          = 1'b1;
    bus.sclk     = 1'b0;
    bus.ss_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_write = 1'b0;
    bus.rx_read  = 1'b0;
    bus.err_clr  = 1'b0;
    cyc(3);
    clr = 1'b0;
    cyc(4);

    chk1("rst_miso", bus.miso, 1'b0);
    chk1("rst_miso_oe", bus.miso_oe, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_tx_full", bus.tx_full, 1'b0);
    chk1("rst_rx_full", bus.rx_full, 1'b0);
    chk8("rst_rx_data", bus.rx_data, 8'h00);
    chk1("rst_overrun", bus.overrun, 1'b0);
    chk1("rst_underrun", bus.underrun, 1'b0);

    // single byte: slave sends A5, master sends 3C
    tx_wr(8'hA5);
    chk1("t1_tx_full_set", bus.tx_full, 1'b1);
    select();
    chk1("t1_busy", bus.busy, 1'b1);
    chk1("t1_miso_oe", bus.miso_oe, 1'b1);
    chk1("t1_tx_full_clr", bus.tx_full, 1'b0);
    spi_bits(8'h3C, 8, got);
    deselect();
    chk8("t1_miso_byte", got, 8'hA5);
    chk8("t1_rx_data", bus.rx_data, 8'h3C);
    chk1("t1_rx_full", bus.rx_full, 1'b1);
    chk1("t1_tx_full", bus.tx_full, 1'b0);
    chk1("t1_overrun", bus.overrun, 1'b0);
    // the LOAD after the last bit finds the TX buffer empty
    chk1("t1_underrun", bus.underrun, 1'b1);
    chk1("t1_busy_end", bus.busy, 1'b0);
    rx_rd();
    chk1("t1_rx_read", bus.rx_full, 1'b0);
    rx_rd();
    chk1("t1_rx_read_empty", bus.rx_full, 1'b0);
    chk8("t1_rx_data_kept", bus.rx_data, 8'h3C);
    err_clear();
    chk1("t1_err_clr", bus.underrun, 1'b0);

    // back-to-back with buffer overwrite, second byte overruns
    tx_wr(8'h55);
    tx_wr(8'h11);
    select();
    tx_wr(8'h22);
    chk1("t2_tx_full_mid", bus.tx_full, 1'b1);
    spi_bits(8'h81, 8, got);
    chk8("t2_miso_b0", got, 8'h11);
    spi_bits(8'h7E, 8, got);
    chk8("t2_miso_b1", got, 8'h22);
    deselect();
    chk8("t2_rx_data", bus.rx_data, 8'h81);
    chk1("t2_rx_full", bus.rx_full, 1'b1);
    chk1("t2_overrun", bus.overrun, 1'b1);
    chk1("t2_underrun", bus.underrun, 1'b1);
    err_clear();
    chk1("t2_ovr_clr", bus.overrun, 1'b0);
    chk1("t2_unr_clr", bus.underrun, 1'b0);
    rx_rd();

    // underrun: nothing written
    select();
    spi_bits(8'hFF, 8, got);
    deselect();
    chk8("t3_miso_byte", got, 8'h00);
    chk1("t3_underrun", bus.underrun, 1'b1);
    chk8("t3_rx_data", bus.rx_data, 8'hFF);
    chk1("t3_rx_full", bus.rx_full, 1'b1);
    chk1("t3_overrun", bus.overrun, 1'b0);
    err_clear();
    chk1("t3_err_clr", bus.underrun, 1'b0);

    // abort after 5 SCLK edges (rise, fall, rise, fall, rise)
    select();
    spi_bits(8'hC0, 2, got);
    bus.mosi = 1'b1;
    half();
    bus.sclk = 1'b1;
    half();
    bus.ss_n = 1'b1;
    cyc(3);
    chk1("t4_busy_abort", bus.busy, 1'b0);
    bus.sclk = 1'b0;
    cyc(4);
    chk1("t4_rx_full_kept", bus.rx_full, 1'b1);
    chk8("t4_rx_data_kept", bus.rx_data, 8'hFF);
    rx_rd();
    select();
    spi_bits(8'h5A, 8, got);
    deselect();
    chk8("t4_rx_data", bus.rx_data, 8'h5A);
    chk1("t4_rx_full", bus.rx_full, 1'b1);
    err_clear();

    // reset mid-transfer
    tx_wr(8'h99);
    select();
    tx_wr(8'h77);
    spi_bits(8'hA0, 3, got);
    clr = 1'b1;
    #1;
    chk1("t5_miso", bus.miso, 1'b0);
    chk1("t5_miso_oe", bus.miso_oe, 1'b0);
    chk1("t5_busy", bus.busy, 1'b0);
    chk1("t5_tx_full", bus.tx_full, 1'b0);
    chk1("t5_rx_full", bus.rx_full, 1'b0);
    chk8("t5_rx_data", bus.rx_data, 8'h00);
    chk1("t5_overrun", bus.overrun, 1'b0);
    chk1("t5_underrun", bus.underrun, 1'b0);
    cyc(2);
    clr = 1'b0;
    cyc(8);
    chk1("t5_no_restart", bus.busy, 1'b0);
    bus.ss_n = 1'b1;
    cyc(4);
    tx_wr(8'hC3);
    select();
    spi_bits(8'h96, 8, got);
    deselect();
    chk8("t5_miso_byte", got, 8'hC3);
    chk8("t5_rx_data_new", bus.rx_data, 8'h96);
    chk1("t5_rx_full_new", bus.rx_full, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
